// File: rtl/and_or_pkg.sv
// and_or_pkg: shared op codes, FSM state encodings and default width for the and_or sequencer
package and_or_pkg;
  localparam int WIDTH = 4;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR = 2'b01;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/and_or_sequencer.sv
// and_or_sequencer: initiator for the combinational and_or unit; request in, unit drive, checked response out
//   clk, rst                      clock, synchronous active-high reset
//   reqValid/reqReady/reqOp/reqA/reqB   request channel (op 00 AND, 01 OR, 1x illegal)
//   doAnd/doOr/aIn/bIn            registered drive to the unit, idle outside DRIVE
//   out/isAnd                     unit result and op indication, sampled in DRIVE
//   rspValid/rspReady/rspData/rspErr    response channel; rspErr flags illegal op or isAnd mismatch
//   opCount                       response-handshake counter, present only with AND_OR_STATS_EN
module and_or_sequencer
  import and_or_pkg::*;
#(
`ifdef AND_OR_STATS_EN
  parameter int CNT_WIDTH = 8,
`endif
  parameter int WIDTH = and_or_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [1:0]       reqOp,
  input  logic [WIDTH-1:0] reqA,
  input  logic [WIDTH-1:0] reqB,
  output logic             doAnd,
  output logic             doOr,
  output logic [WIDTH-1:0] aIn,
  output logic [WIDTH-1:0] bIn,
  input  logic [WIDTH-1:0] out,
  input  logic             isAnd,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
`ifdef AND_OR_STATS_EN
  output logic             rspErr,
  output logic [CNT_WIDTH-1:0] opCount
`else
  output logic             rspErr
`endif
);
  state_t state, state_nx;
  logic accept, legal, taken;
  assign legal = reqOp == OP_AND || reqOp == OP_OR;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = accept ? (legal ? S_DRIVE : S_RESP) : S_IDLE;
      S_DRIVE: state_nx = S_RESP;
      S_RESP:  state_nx = rspReady ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    reqReady = state == S_IDLE;
    rspValid = state == S_RESP;
    accept = reqValid && reqReady;
    taken = rspValid && rspReady;
  end
  // doAnd still holds the requested op during DRIVE, so it is the expected isAnd;
  // !== makes an X/Z indication count as a mismatch in four-state simulation
  always_ff @(posedge clk) begin
    if (rst) begin
      doAnd <= 1'b0;
      doOr <= 1'b0;
      aIn <= '0;
      bIn <= '0;
      rspData <= '0;
      rspErr <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      doAnd <= reqOp == OP_AND;
      doOr <= reqOp == OP_OR;
      aIn <= legal ? reqA : '0;
      bIn <= legal ? reqB : '0;
      rspData <= '0;
      rspErr <= !legal;
    end else if (state == S_DRIVE) begin
      rspData <= out;
      rspErr <= isAnd !== doAnd;
      doAnd <= 1'b0;
      doOr <= 1'b0;
      aIn <= '0;
      bIn <= '0;
    end
  end
`ifdef AND_OR_STATS_EN
  always_ff @(posedge clk) opCount <= rst ? '0 : opCount + CNT_WIDTH'(taken);
`else
  logic unused_taken;
  assign unused_taken = taken;
`endif
endmodule

// File: tb/tb_and_or_sequencer.sv
// tb_and_or_sequencer: directed self-checking bench with a forced-result model of the and_or unit
module tb_and_or_sequencer;
  logic clk, rst, reqValid, reqReady, doAnd, doOr, isAnd, rspValid, rspReady, rspErr;
  logic [1:0] reqOp;
  logic [3:0] reqA, reqB, aIn, bIn, out, rspData;
  int total = 0, bad = 0;
`ifdef AND_OR_STATS_EN
  logic [7:0] opCount;
`endif
  and_or_sequencer dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqA(reqA), .reqB(reqB), .doAnd(doAnd), .doOr(doOr), .aIn(aIn), .bIn(bIn),
    .out(out), .isAnd(isAnd), .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
`ifdef AND_OR_STATS_EN
    .rspErr(rspErr), .opCount(opCount)
`else
    .rspErr(rspErr)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] o, input logic ia);
    logic legal, exp_err;
    logic [3:0] exp_d;
    legal = op < 2'd2;
    exp_err = !legal || (ia !== (op == 2'b00));
    exp_d = legal ? o : 4'd0;
    reqValid = 1'b1;
    reqOp = op;
    reqA = a;
    reqB = b;
    out = o;
    isAnd = ia;
    step();
    reqValid = 1'b0;
    if (legal) begin
      check("drv_and", doAnd, op == 2'b00);
      check("drv_or", doOr, op == 2'b01);
      check("drv_a", aIn, a);
      check("drv_b", bIn, b);
      check("drv_rdy", reqReady, 0);
      check("drv_vld", rspValid, 0);
      step();
    end
    check("rsp_vld", rspValid, 1);
    check("rsp_data", rspData, exp_d);
    check("rsp_err", rspErr, exp_err);
    check("rsp_and", doAnd, 0);
    check("rsp_or", doOr, 0);
    check("rsp_a", aIn, 0);
    check("rsp_rdy", reqReady, 0);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    check("idle_rdy", reqReady, 1);
    check("idle_vld", rspValid, 0);
  endtask
  initial begin
    rst = 1'b1;
    reqValid = 1'b0;
    reqOp = 2'b00;
    reqA = '0;
    reqB = '0;
    out = '0;
    isAnd = 1'b0;
    rspReady = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_rdy", reqReady, 1);
    check("rst_vld", rspValid, 0);
    check("rst_units", {doAnd, doOr, aIn, bIn}, 0);
    check("rst_rsp", {rspErr, rspData}, 0);
`ifdef AND_OR_STATS_EN
    check("rst_cnt", opCount, 0);
`endif
    run_op(2'b00, 4'b1010, 4'b0110, 4'b0001, 1'b1);
    run_op(2'b01, 4'b1010, 4'b0110, 4'b0001, 1'b0);
    run_op(2'b00, 4'b1100, 4'b1010, 4'b1000, 1'b0);
    run_op(2'b00, 4'b0111, 4'b0011, 4'b0011, 1'bx);
    run_op(2'b01, 4'b0101, 4'b0011, 4'b0111, 1'b1);
    run_op(2'b11, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    run_op(2'b10, 4'b0001, 4'b0010, 4'b0011, 1'b0);
    // back-pressure: response held while a second request waits
    reqValid = 1'b1;
    reqOp = 2'b00;
    reqA = 4'b1010;
    reqB = 4'b0110;
    out = 4'b0010;
    isAnd = 1'b1;
    step();
    reqA = 4'b0101;
    reqB = 4'b1001;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rdy", reqReady, 0);
      check("bp_vld", rspValid, 1);
      check("bp_data", rspData, 4'b0010);
      check("bp_a", aIn, 0);
      step();
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    check("bp_idle", reqReady, 1);
    check("bp_gone", rspValid, 0);
    out = 4'b0001;
    step();
    reqValid = 1'b0;
    check("bp_acc_a", aIn, 4'b0101);
    check("bp_acc_b", bIn, 4'b1001);
    check("bp_acc_and", doAnd, 1);
    step();
    check("bp2_data", rspData, 4'b0001);
    check("bp2_err", rspErr, 0);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    // reset during DRIVE aborts the operation
    reqValid = 1'b1;
    reqOp = 2'b01;
    reqA = 4'b1111;
    reqB = 4'b0001;
    step();
    reqValid = 1'b0;
    check("ab_drv_or", doOr, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ab_units", {doAnd, doOr, aIn, bIn}, 0);
    check("ab_rsp", {rspValid, rspErr, rspData}, 0);
    check("ab_rdy", reqReady, 1);
    step();
    step();
    check("ab_norsp", rspValid, 0);
`ifdef AND_OR_STATS_EN
    check("ab_cnt", opCount, 0);
    out = 4'b0000;
    isAnd = 1'b1;
    reqOp = 2'b00;
    for (int i = 1; i <= 256; i++) begin
      reqValid = 1'b1;
      reqOp = (i % 4 == 0) ? 2'b11 : 2'b00;
      step();
      reqValid = 1'b0;
      if (reqOp == 2'b00) step();
      rspReady = 1'b1;
      step();
      rspReady = 1'b0;
      if (i == 1) check("cnt_1", opCount, 1);
      if (i == 255) check("cnt_255", opCount, 255);
    end
    check("cnt_wrap", opCount, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/and_or_sequencer.md
Name: and_or_sequencer

Overview:
- Initiator side of the and_or interface. Accepts operation requests on a valid/ready channel and drives doAnd/doOr/aIn/bIn to the combinational and_or unit.
- Samples the unit's out/isAnd, checks that isAnd matches the requested operation, and returns a buffered response on a valid/ready channel.
- Sits between the control pipeline and the and_or datapath. It is the only block that drives the unit's select lines.

Parameters:
WIDTH, 4, operand/result width; must match the and_or unit (4).
CNT_WIDTH, 8, width of the optional operation counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
reqValid  input  1  request present.
reqReady  output  1  sequencer can accept a request.
reqOp  input  2  2'b00 AND, 2'b01 OR, 2'b10/2'b11 illegal.
reqA  input  WIDTH  operand A.
reqB  input  WIDTH  operand B.
doAnd  output  1  to unit; registered.
doOr  output  1  to unit; registered.
aIn  output  WIDTH  to unit; registered.
bIn  output  WIDTH  to unit; registered.
out  input  WIDTH  result from unit (combinational).
isAnd  input  1  op indication from unit.
rspValid  output  1  response present.
rspReady  input  1  consumer accepts response.
rspData  output  WIDTH  captured result.
rspErr  output  1  illegal op or isAnd mismatch.
opCount  output  CNT_WIDTH  only when AND_OR_STATS_EN is defined.

Behaviour:
- Reset, synchronous, rst=1 at a clock edge:
  - State goes to IDLE.
  - doAnd, doOr, aIn, bIn, rspValid, rspData, rspErr and opCount all go to 0.
  - reqReady is 1 the cycle after reset deasserts.
- FSM states are IDLE, DRIVE, RESP.
- IDLE:
  - reqReady=1; doAnd=doOr=0; aIn and bIn hold 0.
  - Accept occurs on reqValid&&reqReady.
  - Legal op: register aIn=reqA, bIn=reqB, doAnd=(op==00), doOr=(op==01), then go to DRIVE.
  - Illegal op: unit lines stay idle; go straight to RESP with rspData=0 and rspErr=1.
- DRIVE (exactly one cycle):
  - reqReady=0.
  - At the clock edge, capture rspData=out and rspErr=(isAnd !== expected), where expected is 1 for AND and 0 for OR. X or Z on isAnd counts as a mismatch.
  - Also clear doAnd, doOr, aIn and bIn to 0, then go to RESP.
- RESP:
  - rspValid=1; rspData and rspErr are stable until the handshake.
  - On rspReady=1: rspValid goes to 0 at the next edge and the state returns to IDLE.
  - rspReady is ignored when rspValid=0.
- Latency:
  - Accept at edge N gives DRIVE during cycle N+1 and rspValid=1 in cycle N+2.
  - Illegal op accepted at edge N gives rspValid=1 in cycle N+1.
- Throughput: at most one request per 3 cycles. reqReady=0 in DRIVE and RESP, so there is no overlap.
- Back-pressure: rspReady held low keeps the block in RESP indefinitely with outputs unchanged. A new request is not accepted until that response is taken.
- doAnd and doOr are never both 1. Both are 0 outside DRIVE.
- reqOp, reqA and reqB are sampled only on accept; changes while reqReady=0 are ignored.
- rst asserted in any state aborts the operation and discards any pending response; no response is produced.

Optional Feature:
- Macro: AND_OR_STATS_EN.
- Defined:
  - Port opCount exists.
  - It increments by 1 on every response handshake (rspValid&&rspReady), including error responses.
  - It wraps from 2^CNT_WIDTH-1 to 0 and is cleared by rst.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package and_or_pkg holds:
  - Op-code localparams OP_AND=2'b00 and OP_OR=2'b01.
  - State encodings S_IDLE, S_DRIVE, S_RESP.
  - WIDTH default 4.
- No sub-module needed; the FSM, operand registers and response register live in one module.
- The bench instantiates the real and_or unit or a behavioural model of it.

Test Plan:
- AND request, reqA=4'b1010, reqB=4'b0110; model returns out=4'b0001, isAnd=1 -> doAnd=1/doOr=0 in cycle N+1; rspValid in cycle N+2 with rspData=4'b0001, rspErr=0.
- OR request; model returns out=4'b0001, isAnd=0 -> doOr=1/doAnd=0 in DRIVE; rspData=4'b0001, rspErr=0.
- AND request with model returning isAnd=0, then isAnd=1'bx -> rspErr=1 both times; rspData equals sampled out.
- reqOp=2'b11 -> doAnd=doOr=0 throughout; rspValid in cycle N+1 with rspData=0, rspErr=1.
- rspReady held 0 for 5 cycles with reqValid=1 and a different operand -> reqReady=0 throughout; rspData stable; after rspReady=1, IDLE next cycle and the second request is accepted.
- rst pulsed during DRIVE -> next cycle all outputs 0, reqReady=1, no response. With AND_OR_STATS_EN, 256 completed ops at CNT_WIDTH=8 -> opCount wraps to 0.
